ovf_snapshot_unit: RTL and testbench
====================================

OVF_SNAPSHOT_UNIT -- requirements
Module: ovf_snapshot_unit

Interface
REQ-001 Parameter HI_W, default 16: width of the overflow-extension counter.
REQ-002 Parameter IRQ_THRESH, default 100: ovf_hi value that raises irq.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cnt_in  input  8  live count from the upstream 8-bit counter.
REQ-006 ovf_in  input  1  upstream wrap flag, one cycle per 255->0 wrap, registered together with cnt_in=0.
REQ-007 clear  input  1  synchronous clear of ovf_hi and the sticky flags.
REQ-008 snap_req  input  1  snapshot request, sampled only in IDLE.
REQ-009 out_ready  input  1  downstream accepts snapshot.
REQ-010 snap_valid  output  1  snapshot held and valid.
REQ-011 snap_data  output  HI_W+8  extended count {hi, lo}.
REQ-012 ovf_hi  output  HI_W  running overflow count.
REQ-013 sat  output  1  sticky: ovf_hi reached all-ones.
REQ-014 snap_lost  output  1  sticky: snap_req dropped while busy.
REQ-015 irq  output  1  single-cycle threshold pulse.

Function
REQ-016 ovf_hi SHALL increment by 1 on each cycle with ovf_in=1, saturating at all-ones, with no wrap.
REQ-017 sat SHALL set on the cycle ovf_hi becomes all-ones and hold until clear or reset.
REQ-018 The FSM SHALL have two states: IDLE (snap_valid=0) and HOLD (snap_valid=1).
REQ-019 IDLE->HOLD SHALL occur when snap_req=1 in cycle N, with snap_valid=1 in cycle N+1 (latency 1).
REQ-020 The captured value SHALL be {sat_add(ovf_hi, ovf_in), cnt_in} sampled in cycle N, so a wrap in cycle N is counted.
REQ-021 HOLD->IDLE SHALL occur on the edge where snap_valid=1 and out_ready=1.
REQ-022 While in HOLD, snap_data SHALL remain stable regardless of cnt_in, ovf_in, or clear.
REQ-023 snap_req=1 in HOLD SHALL be ignored and SHALL set snap_lost.
REQ-024 snap_req=1 in HOLD on the same cycle as the accepting handshake SHALL also be lost; back-to-back snapshots need one IDLE cycle.
REQ-025 clear=1 SHALL zero ovf_hi, sat, and snap_lost next cycle, and SHALL take priority over a simultaneous ovf_in or snap_req-lost event.
REQ-026 clear SHALL NOT abort a snapshot held in HOLD.
REQ-027 A snapshot captured on a clear cycle SHALL use pre-clear values.
REQ-028 irq SHALL pulse for one cycle when ovf_hi transitions from IRQ_THRESH-1 to IRQ_THRESH, and never otherwise.

Reset
REQ-029 rst_n=0 at a clock edge SHALL set the state to IDLE, snap_valid=0, snap_data=0, ovf_hi=0, sat=0, snap_lost=0, irq=0.
REQ-030 Reset SHALL override every other input and SHALL discard a snapshot in HOLD without handshake.

Configuration
REQ-031 Macro OVF_SNAP_IRQ_EN, when defined, SHALL compile in the irq threshold logic per REQ-028.
REQ-032 Without OVF_SNAP_IRQ_EN, irq SHALL be tied to 0, IRQ_THRESH SHALL be unused, and the port list SHALL remain unchanged.

Structure
REQ-033 Package ovf_snap_pkg SHALL hold the FSM state enum (IDLE, HOLD), the LO_W=8 constant, and the default HI_W.
REQ-034 Sub-module ovf_sat_cnt SHALL provide the saturating HI_W counter with clear, inc, and at_max.
REQ-035 The FSM, capture register, and sticky flags SHALL reside in ovf_snapshot_unit.

Verification
REQ-036 Reset, then 3 ovf_in pulses with cnt_in=0x10 and snap_req -> snap_data=0x00000310 one cycle later; held until out_ready.
REQ-037 snap_req with ovf_in=1, cnt_in=0x00, ovf_hi=5 -> snap_data=0x000600.
REQ-038 Second snap_req during HOLD -> ignored, snap_lost=1, first data unchanged; clear -> snap_lost=0, HOLD intact.
REQ-039 HI_W=4, 16 ovf_in pulses -> ovf_hi=0xF, sat=1; clear with ovf_in=1 same cycle -> ovf_hi=0.
REQ-040 OVF_SNAP_IRQ_EN, IRQ_THRESH=3, 5 ovf_in pulses -> exactly one irq pulse, the cycle after the third pulse; undefined -> irq always 0.
REQ-041 rst_n=0 while in HOLD -> snap_valid=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/ovf_snap_pkg.sv
// Shared definitions for the overflow snapshot unit: FSM state encoding,
// width of the live (low) count and the default width of the extension counter.
package ovf_snap_pkg;

    // Low part of the extended count comes straight from the upstream 8-bit counter.
    localparam int LO_W     = 8;

    // Default width of the overflow-extension (high) counter.
    localparam int HI_W_DEF = 16;

    // Snapshot handshake states: IDLE = no snapshot held, HOLD = snapshot valid.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } snap_state_e;

endpackage : ovf_snap_pkg

// File: rtl/ovf_sat_cnt.sv
// Saturating HI_W-bit overflow-extension counter.
// count     : registered running value.
// count_inc : count plus this cycle's increment (saturated), ignoring clear.
//             The parent uses it to capture a snapshot that already includes a
//             wrap happening in the capture cycle.
// at_max    : count_inc is all-ones, i.e. the register becomes (or stays)
//             saturated on the next edge unless cleared.
module ovf_sat_cnt
    import ovf_snap_pkg::*;
#(
    parameter int HI_W = HI_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            inc,
    output logic [HI_W-1:0] count,
    output logic [HI_W-1:0] count_inc,
    output logic            at_max
);

    localparam logic [HI_W-1:0] ALL_ONES = {HI_W{1'b1}};
    localparam logic [HI_W-1:0] ZERO     = {HI_W{1'b0}};
    localparam logic [HI_W-1:0] ONE      = {{(HI_W-1){1'b0}}, 1'b1};

    logic [HI_W-1:0] count_r;
    logic [HI_W-1:0] count_s;

    // Saturating increment: once all-ones, further increments are dropped.
    always_comb begin
        count_inc = count_r;
        if (inc && (count_r != ALL_ONES)) begin
            count_inc = count_r + ONE;
        end else begin
            count_inc = count_r;
        end
    end

    assign at_max = (count_inc == ALL_ONES);

    // Next register value; clear wins over a simultaneous increment.
    always_comb begin
        count_s = count_r;
        if (clear) begin
            count_s = ZERO;
        end else begin
            count_s = count_inc;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= ZERO;
        end else begin
            count_r <= count_s;
        end
    end

    assign count = count_r;

endmodule : ovf_sat_cnt

// File: rtl/ovf_snapshot_unit.sv
// Overflow snapshot unit: extends an upstream 8-bit counter with a saturating
// HI_W-bit overflow count and offers {hi, lo} snapshots through a
// valid/ready handshake, plus sticky saturation / lost-request flags.
// Optional feature: define OVF_SNAP_IRQ_EN to build the irq threshold pulse
// (ovf_hi stepping from IRQ_THRESH-1 to IRQ_THRESH). Without it irq is
// constant 0 and IRQ_THRESH has no effect; the port list is identical.
module ovf_snapshot_unit
    import ovf_snap_pkg::*;
#(
    parameter int HI_W       = HI_W_DEF,
    parameter int IRQ_THRESH = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LO_W-1:0]      cnt_in,
    input  logic                 ovf_in,
    input  logic                 clear,
    input  logic                 snap_req,
    input  logic                 out_ready,
    output logic                 snap_valid,
    output logic [HI_W+LO_W-1:0] snap_data,
    output logic [HI_W-1:0]      ovf_hi,
    output logic                 sat,
    output logic                 snap_lost,
    output logic                 irq
);

    localparam int SNAP_W = HI_W + LO_W;

    snap_state_e         state_r;
    snap_state_e         state_s;
    logic                capture_s;
    logic [SNAP_W-1:0]   snap_data_r;
    logic [SNAP_W-1:0]   snap_data_s;
    logic                sat_r;
    logic                sat_s;
    logic                lost_r;
    logic                lost_s;
    logic [HI_W-1:0]     hi_inc_s;
    logic                hi_at_max_s;

    ovf_sat_cnt #(
        .HI_W (HI_W)
    ) u_hi_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .inc       (ovf_in),
        .count     (ovf_hi),
        .count_inc (hi_inc_s),
        .at_max    (hi_at_max_s)
    );

    // Snapshot FSM next state; a request is only taken from IDLE, so a
    // request on the accepting handshake cycle is not turned into a capture.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (snap_req) begin
                    state_s   = HOLD;
                    capture_s = 1'b1;
                end else begin
                    state_s   = IDLE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Capture uses the count including this cycle's wrap and ignores clear,
    // so a capture on a clear cycle still sees the pre-clear value.
    always_comb begin
        snap_data_s = snap_data_r;
        if (capture_s) begin
            snap_data_s = {hi_inc_s, cnt_in};
        end else begin
            snap_data_s = snap_data_r;
        end
    end

    // Sticky flags; clear takes priority over any simultaneous set event.
    always_comb begin
        sat_s  = sat_r;
        lost_s = lost_r;
        if (clear) begin
            sat_s  = 1'b0;
            lost_s = 1'b0;
        end else begin
            sat_s  = sat_r | hi_at_max_s;
            if ((state_r == HOLD) && snap_req) begin
                lost_s = 1'b1;
            end else begin
                lost_s = lost_r;
            end
        end
    end

    // State, capture and sticky-flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            snap_data_r <= {SNAP_W{1'b0}};
            sat_r       <= 1'b0;
            lost_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            snap_data_r <= snap_data_s;
            sat_r       <= sat_s;
            lost_r      <= lost_s;
        end
    end

    assign snap_valid = (state_r == HOLD);
    assign snap_data  = snap_data_r;
    assign sat        = sat_r;
    assign snap_lost  = lost_r;

`ifdef OVF_SNAP_IRQ_EN
    localparam logic [31:0] THRESH_U = 32'(IRQ_THRESH);

    logic irq_r;
    logic irq_s;

    // Threshold pulse: only a real increment landing exactly on the threshold fires.
    always_comb begin
        irq_s = 1'b0;
        if (!clear && (hi_inc_s != ovf_hi) && (32'(hi_inc_s) == THRESH_U)) begin
            irq_s = 1'b1;
        end else begin
            irq_s = 1'b0;
        end
    end

    // Registered single-cycle irq pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_s;
        end
    end

    assign irq = irq_r;
`else
    assign irq = 1'b0;
`endif

endmodule : ovf_snapshot_unit

// File: tb/tb_ovf_snapshot_unit.sv
// Self-checking bench for ovf_snapshot_unit. Two instances share stimulus:
// d0 with HI_W=16 and d1 with HI_W=4 (to reach saturation), both IRQ_THRESH=3.
// An integer-level reference model tracks both instances each clock.
module tb_ovf_snapshot_unit;

`ifdef OVF_SNAP_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam int THRESH = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cnt_in;
    logic        ovf_in;
    logic        clear;
    logic        snap_req;
    logic        out_ready;

    logic        d0_valid, d0_sat, d0_lost, d0_irq;
    logic [23:0] d0_data;
    logic [15:0] d0_hi;
    logic        d1_valid, d1_sat, d1_lost, d1_irq;
    logic [11:0] d1_data;
    logic [3:0]  d1_hi;

    int errors = 0;
    int checks = 0;

    // reference model state, index 0 = d0 (16-bit), 1 = d1 (4-bit)
    int          m_hi   [2];
    bit          m_sat  [2];
    bit          m_lost [2];
    bit          m_hold [2];
    bit          m_irq  [2];
    logic [31:0] m_data [2];

    always #5 clk = ~clk;

    ovf_snapshot_unit #(.HI_W(16), .IRQ_THRESH(THRESH)) dut0 (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .ovf_in(ovf_in), .clear(clear),
        .snap_req(snap_req), .out_ready(out_ready), .snap_valid(d0_valid),
        .snap_data(d0_data), .ovf_hi(d0_hi), .sat(d0_sat), .snap_lost(d0_lost), .irq(d0_irq));

    ovf_snapshot_unit #(.HI_W(4), .IRQ_THRESH(THRESH)) dut1 (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .ovf_in(ovf_in), .clear(clear),
        .snap_req(snap_req), .out_ready(out_ready), .snap_valid(d1_valid),
        .snap_data(d1_data), .ovf_hi(d1_hi), .sat(d1_sat), .snap_lost(d1_lost), .irq(d1_irq));

    // Model one clock edge for both widths using the currently driven inputs.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int mx;
            int nxt;
            bit was_hold;
            mx = (k == 0) ? 65535 : 15;
            if (!rst_n) begin
                m_hi[k] = 0; m_sat[k] = 1'b0; m_lost[k] = 1'b0;
                m_hold[k] = 1'b0; m_irq[k] = 1'b0; m_data[k] = 32'h0;
            end else begin
                was_hold = m_hold[k];
                nxt = (ovf_in && m_hi[k] < mx) ? m_hi[k] + 1 : m_hi[k];
                m_irq[k] = IRQ_ON && !clear && (nxt != m_hi[k]) && (nxt == THRESH);
                if (!was_hold && snap_req) begin
                    m_data[k] = (32'(nxt) << 8) | 32'(cnt_in);
                    m_hold[k] = 1'b1;
                end else if (was_hold && out_ready) begin
                    m_hold[k] = 1'b0;
                end
                if (clear) m_lost[k] = 1'b0;
                else if (was_hold && snap_req) m_lost[k] = 1'b1;
                if (clear) begin
                    m_hi[k] = 0; m_sat[k] = 1'b0;
                end else begin
                    m_hi[k] = nxt; m_sat[k] = m_sat[k] || (nxt == mx);
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, settle past the edge.
    task automatic step(input logic r, input logic [7:0] c, input logic o,
                        input logic cl, input logic sr, input logic rdy);
        rst_n = r; cnt_in = c; ovf_in = o; clear = cl; snap_req = sr; out_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({d0_valid, d0_sat, d0_lost, d0_irq, d1_valid, d1_sat, d1_lost, d1_irq} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000000",
                     {d0_valid, d0_sat, d0_lost, d0_irq, d1_valid, d1_sat, d1_lost, d1_irq});
        end
        checks++;
        if (d0_data !== 24'h0 || d1_data !== 12'h0) begin
            errors++; $display("FAIL reset_data got=%h/%h exp=0", d0_data, d1_data);
        end
        checks++;
        if (d0_hi !== 16'h0 || d1_hi !== 4'h0) begin
            errors++; $display("FAIL reset_hi got=%h/%h exp=0", d0_hi, d1_hi);
        end
    endtask

    task automatic test_basic_snapshot();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (d0_irq !== ((i == 2) ? IRQ_ON : 1'b0)) begin
                errors++; $display("FAIL basic_irq pulse=%0d got=%b exp=%b", i, d0_irq, (i == 2) ? IRQ_ON : 1'b0);
            end
        end
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (d0_valid !== 1'b1 || d0_data !== 24'h000310) begin
            errors++; $display("FAIL basic_capture got=%b/%h exp=1/000310", d0_valid, d0_data);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'($urandom), 1'($urandom), (i == 2) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            checks++;
            if (d0_valid !== 1'b1 || d0_data !== 24'h000310) begin
                errors++; $display("FAIL basic_hold cyc=%0d got=%b/%h exp=1/000310", i, d0_valid, d0_data);
            end
        end
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (d0_valid !== 1'b0) begin
            errors++; $display("FAIL basic_release got=%b exp=0", d0_valid);
        end
    endtask

    task automatic test_capture_wrap();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (d0_data !== 24'h000600 || d0_hi !== 16'd6) begin
            errors++; $display("FAIL wrap_capture got=%h hi=%0d exp=000600 hi=6", d0_data, d0_hi);
        end
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_lost_and_clear();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (d0_lost !== 1'b1 || d0_valid !== 1'b1 || d0_data !== 24'h0000A5) begin
            errors++; $display("FAIL lost_set got=%b/%b/%h exp=1/1/0000a5", d0_lost, d0_valid, d0_data);
        end
        step(1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (d0_lost !== 1'b0 || d0_valid !== 1'b1 || d0_data !== 24'h0000A5 || d0_hi !== 16'h0) begin
            errors++; $display("FAIL lost_clear got=%b/%b/%h/%h exp=0/1/0000a5/0000", d0_lost, d0_valid, d0_data, d0_hi);
        end
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (d0_valid !== 1'b0 || d0_lost !== 1'b1) begin
            errors++; $display("FAIL lost_on_handshake got=%b/%b exp=0/1", d0_valid, d0_lost);
        end
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (d0_valid !== 1'b1 || d0_data !== 24'h000077) begin
            errors++; $display("FAIL lost_recapture got=%b/%h exp=1/000077", d0_valid, d0_data);
        end
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (d1_hi !== 4'((i > 15) ? 15 : i) || d1_sat !== (i >= 15)) begin
                errors++; $display("FAIL sat_count pulse=%0d got=%h/%b exp=%h/%b", i, d1_hi, d1_sat,
                                   4'((i > 15) ? 15 : i), (i >= 15));
            end
        end
        step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (d1_hi !== 4'h0 || d1_sat !== 1'b0 || d0_hi !== 16'h0) begin
            errors++; $display("FAIL sat_clear got=%h/%b/%h exp=0/0/0", d1_hi, d1_sat, d0_hi);
        end
    endtask

    task automatic test_irq();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 8'h00, (i <= 5) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (d0_irq !== ((i == 3) ? IRQ_ON : 1'b0) || d1_irq !== ((i == 3) ? IRQ_ON : 1'b0)) begin
                errors++; $display("FAIL irq_pulse cyc=%0d got=%b/%b exp=%b", i, d0_irq, d1_irq,
                                   (i == 3) ? IRQ_ON : 1'b0);
            end
        end
    endtask

    task automatic test_reset_in_hold();
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (d0_valid !== 1'b1) begin
            errors++; $display("FAIL rsthold_enter got=%b exp=1", d0_valid);
        end
        step(1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({d0_valid, d0_sat, d0_lost, d0_irq, d1_valid, d1_sat, d1_lost, d1_irq} !== 8'h00 ||
            d0_data !== 24'h0 || d0_hi !== 16'h0 || d1_data !== 12'h0 || d1_hi !== 4'h0) begin
            errors++; $display("FAIL rsthold_clear got=%b/%h/%h exp=0/0/0", d0_valid, d0_data, d0_hi);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(63) != 0) ? 1'b1 : 1'b0, 8'($urandom), 1'($urandom),
                 ($urandom_range(15) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(2) == 0) ? 1'b1 : 1'b0, 1'($urandom));
            checks++;
            if (d0_valid !== m_hold[0] || d0_data !== m_data[0][23:0] || d0_hi !== 16'(m_hi[0])) begin
                errors++; $display("FAIL rnd_d0_snap cyc=%0d got=%b/%h/%h exp=%b/%h/%h", i, d0_valid, d0_data,
                                   d0_hi, m_hold[0], m_data[0][23:0], 16'(m_hi[0]));
            end
            checks++;
            if (d0_sat !== m_sat[0] || d0_lost !== m_lost[0] || d0_irq !== m_irq[0]) begin
                errors++; $display("FAIL rnd_d0_flags cyc=%0d got=%b%b%b exp=%b%b%b", i, d0_sat, d0_lost, d0_irq,
                                   m_sat[0], m_lost[0], m_irq[0]);
            end
            checks++;
            if (d1_valid !== m_hold[1] || d1_data !== m_data[1][11:0] || d1_hi !== 4'(m_hi[1])) begin
                errors++; $display("FAIL rnd_d1_snap cyc=%0d got=%b/%h/%h exp=%b/%h/%h", i, d1_valid, d1_data,
                                   d1_hi, m_hold[1], m_data[1][11:0], 4'(m_hi[1]));
            end
            checks++;
            if (d1_sat !== m_sat[1] || d1_lost !== m_lost[1] || d1_irq !== m_irq[1]) begin
                errors++; $display("FAIL rnd_d1_flags cyc=%0d got=%b%b%b exp=%b%b%b", i, d1_sat, d1_lost, d1_irq,
                                   m_sat[1], m_lost[1], m_irq[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_snapshot();
        test_capture_wrap();
        test_lost_and_clear();
        test_saturation();
        test_irq();
        test_reset_in_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ovf_snapshot_unit
